// File: rtl/viterbi_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : viterbi_ctrl
//  Brief    : Block sequencer for a radix-4 Viterbi decoder. It walks one
//             block through ACS/survivor write, best-node select, traceback
//             and byte output.
//  Revision : 1.0 - initial release
// ============================================================================
module viterbi_ctrl #(
    parameter int STEPS      = 4,
    parameter int TB_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_in_valid,
    output logic       o_in_ready,
    output logic       o_acs_en,
    output logic       o_mem_wr,
    output logic [1:0] o_mem_addr,
    output logic       o_td_empty,
    output logic       o_sel_start,
    input  logic       i_sel_done,
    output logic       o_en_t,
    input  logic       i_decoder_done,
    input  logic [7:0] i_decoder_data,
    output logic       o_out_valid,
    output logic [7:0] o_out_data,
    input  logic       i_out_ready,
    output logic       o_busy,
    output logic       o_err
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ACS  = 3'd1,
        SEL  = 3'd2,
        TB   = 3'd3,
        OUT  = 3'd4
    } state_t;

    // The step index doubles as the 2-bit survivor address, so STEPS is 1..4.
    localparam int               c_cnt_w     = $clog2(TB_TIMEOUT + 1);
    localparam logic [1:0]       c_last_step = 2'(STEPS - 1);
    localparam logic [c_cnt_w-1:0] c_tb_last = c_cnt_w'(TB_TIMEOUT - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

    state_t               r_state;
    logic [1:0]           r_step;
    logic [c_cnt_w-1:0]   r_tb_cnt;
    logic                 w_in_hs;

    assign w_in_hs = i_in_valid && o_in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_step      <= 2'd0;
            r_tb_cnt    <= '0;
            o_in_ready  <= 1'b0;
            o_acs_en    <= 1'b0;
            o_mem_wr    <= 1'b0;
            o_mem_addr  <= 2'd0;
            o_td_empty  <= 1'b1;
            o_sel_start <= 1'b0;
            o_en_t      <= 1'b0;
            o_out_valid <= 1'b0;
            o_out_data  <= 8'h00;
            o_busy      <= 1'b0;
            o_err       <= 1'b0;
        end else begin
            o_acs_en    <= 1'b0;
            o_mem_wr    <= 1'b0;
            o_sel_start <= 1'b0;

            case (r_state)
                // IDLE always holds step 0, so both states share the intake path.
                IDLE, ACS: begin
                    o_in_ready <= 1'b1;
                    if (w_in_hs) begin
                        o_acs_en   <= 1'b1;
                        o_mem_wr   <= 1'b1;
                        o_mem_addr <= r_step;
                        o_td_empty <= 1'b0;
                        o_busy     <= 1'b1;
                        if (r_step == c_last_step) begin
                            r_step      <= 2'd0;
                            r_state     <= SEL;
                            o_in_ready  <= 1'b0;
                            o_sel_start <= 1'b1;
                        end else begin
                            r_step  <= r_step + 2'd1;
                            r_state <= ACS;
                        end
                    end else begin
                        o_td_empty <= (r_step == 2'd0);
                        o_busy     <= (r_state != IDLE);
                    end
                end

                SEL: begin
                    if (i_sel_done) begin
                        r_state  <= TB;
                        r_tb_cnt <= '0;
                        o_en_t   <= 1'b1;
                    end
                end

                // A done in the final allowed cycle still wins over the timeout.
                TB: begin
                    if (i_decoder_done) begin
                        o_out_data  <= i_decoder_data;
                        o_out_valid <= 1'b1;
                        o_en_t      <= 1'b0;
                        r_tb_cnt    <= '0;
                        r_state     <= OUT;
                    end else if (r_tb_cnt == c_tb_last) begin
                        o_err       <= 1'b1;
                        o_en_t      <= 1'b0;
                        r_tb_cnt    <= '0;
                        r_state     <= IDLE;
                        o_busy      <= 1'b0;
                        o_td_empty  <= 1'b1;
                        o_in_ready  <= 1'b1;
                    end else begin
                        r_tb_cnt <= r_tb_cnt + c_cnt_one;
                    end
                end

                OUT: begin
                    if (i_out_ready) begin
                        o_out_valid <= 1'b0;
                        r_state     <= IDLE;
                        o_busy      <= 1'b0;
                        o_td_empty  <= 1'b1;
                        o_in_ready  <= 1'b1;
                    end
                end

                default: begin
                    r_state    <= IDLE;
                    r_step     <= 2'd0;
                    r_tb_cnt   <= '0;
                    o_en_t     <= 1'b0;
                    o_busy     <= 1'b0;
                    o_td_empty <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_viterbi_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_viterbi_ctrl
//  Brief    : Self-checking bench for viterbi_ctrl; randomized blocks scored
//             against a block-level model of the expected outcome.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_viterbi_ctrl;

    localparam int STEPS      = 4;
    localparam int TB_TIMEOUT = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_in_valid;
    logic       o_in_ready;
    logic       o_acs_en;
    logic       o_mem_wr;
    logic [1:0] o_mem_addr;
    logic       o_td_empty;
    logic       o_sel_start;
    logic       i_sel_done;
    logic       o_en_t;
    logic       i_decoder_done;
    logic [7:0] i_decoder_data;
    logic       o_out_valid;
    logic [7:0] o_out_data;
    logic       i_out_ready;
    logic       o_busy;
    logic       o_err;

    int n_checks = 0;
    int n_pass   = 0;
    bit exp_err  = 1'b0;

    viterbi_ctrl #(
        .STEPS      (STEPS),
        .TB_TIMEOUT (TB_TIMEOUT)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .i_in_valid     (i_in_valid),
        .o_in_ready     (o_in_ready),
        .o_acs_en       (o_acs_en),
        .o_mem_wr       (o_mem_wr),
        .o_mem_addr     (o_mem_addr),
        .o_td_empty     (o_td_empty),
        .o_sel_start    (o_sel_start),
        .i_sel_done     (i_sel_done),
        .o_en_t         (o_en_t),
        .i_decoder_done (i_decoder_done),
        .i_decoder_data (i_decoder_data),
        .o_out_valid    (o_out_valid),
        .o_out_data     (o_out_data),
        .i_out_ready    (i_out_ready),
        .o_busy         (o_busy),
        .o_err          (o_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual 0x%0h required 0x%0h", tag, act, exp);
    endtask

    task automatic clear_inputs();
        i_in_valid     = 1'b0;
        i_sel_done     = 1'b0;
        i_decoder_done = 1'b0;
        i_decoder_data = 8'h00;
        i_out_ready    = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ":in_ready"},  32'(o_in_ready),  32'd0);
        check({tag, ":acs_en"},    32'(o_acs_en),    32'd0);
        check({tag, ":mem_wr"},    32'(o_mem_wr),    32'd0);
        check({tag, ":mem_addr"},  32'(o_mem_addr),  32'd0);
        check({tag, ":td_empty"},  32'(o_td_empty),  32'd1);
        check({tag, ":sel_start"}, 32'(o_sel_start), 32'd0);
        check({tag, ":en_t"},      32'(o_en_t),      32'd0);
        check({tag, ":out_valid"}, 32'(o_out_valid), 32'd0);
        check({tag, ":out_data"},  32'(o_out_data),  32'd0);
        check({tag, ":busy"},      32'(o_busy),      32'd0);
        check({tag, ":err"},       32'(o_err),       32'd0);
    endtask

    // Leaves the bench at a falling edge with the controller ready in IDLE.
    task automatic release_reset(input string tag);
        rst = 1'b1;
        #1 check({tag, ":ready_pre_edge"}, 32'(o_in_ready), 32'd0);
        @(negedge clk);
        check({tag, ":ready_post_edge"}, 32'(o_in_ready), 32'd1);
        exp_err = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0;
        clear_inputs();
        repeat (3) @(negedge clk);
        check_reset_values(tag);
        release_reset(tag);
    endtask

    // pat_len > 0: explicit valid pattern; 0: back-to-back; < 0: random gaps.
    // done_at == 0: traceback never reports done. abort_at: reset in that TB cycle.
    task automatic run_block(input string name, input int sel_dly, input int done_at,
                             input logic [7:0] data, input int rdy_dly,
                             input logic [15:0] pat, input int pat_len, input int abort_at);
        int         hs_sent = 0, pat_idx = 0, acs_cnt = 0, sel_cnt = 0, en_cnt = 0, val_cnt = 0;
        int         sel_wait = -1, cyc = 0, last_acs_cyc = -1, sel_cyc = -1;
        logic [1:0] addrs[$];
        logic       v;
        bit         finished = 1'b0;
        bit         timeout;

        while (!finished) begin
            if (o_acs_en) begin
                acs_cnt++;
                addrs.push_back(o_mem_addr);
                last_acs_cyc = cyc;
                check({name, ":mem_wr"},   32'(o_mem_wr),   32'd1);
                check({name, ":td_empty"}, 32'(o_td_empty), 32'd0);
                check({name, ":acs_vs_ent"}, 32'(o_en_t),   32'd0);
            end
            if (o_sel_start) begin
                sel_cnt++;
                sel_cyc  = cyc;
                sel_wait = 0;
                check({name, ":sel_vs_ent"}, 32'(o_en_t), 32'd0);
            end
            if (o_en_t) begin
                en_cnt++;
                check({name, ":tb_ready"}, 32'(o_in_ready), 32'd0);
            end
            if (o_out_valid) begin
                val_cnt++;
                check({name, ":out_data"},  32'(o_out_data), 32'(data));
                check({name, ":out_ready"}, 32'(o_in_ready), 32'd0);
                check({name, ":out_acs"},   32'(o_acs_en),   32'd0);
            end
            if (hs_sent == STEPS && !o_busy) finished = 1'b1;

            if (!finished) begin
                if (abort_at != 0 && o_en_t && en_cnt == abort_at) begin
                    #2 rst = 1'b0;
                    #1;
                    check({name, ":abort_en_t"},  32'(o_en_t),      32'd0);
                    check({name, ":abort_err"},   32'(o_err),       32'd0);
                    check({name, ":abort_busy"},  32'(o_busy),      32'd0);
                    check({name, ":abort_valid"}, 32'(o_out_valid), 32'd0);
                    check({name, ":abort_ready"}, 32'(o_in_ready),  32'd0);
                    clear_inputs();
                    @(negedge clk);
                    release_reset(name);
                    return;
                end

                if (o_in_ready) begin
                    if (hs_sent < STEPS) begin
                        if (pat_len > 0) v = (pat_idx < pat_len) ? pat[pat_idx] : 1'b1;
                        else if (pat_len == 0) v = 1'b1;
                        else v = 1'($urandom_range(0, 1));
                        pat_idx++;
                    end else begin
                        v = 1'b0;
                    end
                end else begin
                    v = 1'b1;
                end
                i_in_valid = v;
                if (o_in_ready && v) hs_sent++;

                i_sel_done = 1'b0;
                if (sel_wait >= 0) begin
                    if (sel_wait == sel_dly) begin
                        i_sel_done = 1'b1;
                        sel_wait   = -1;
                    end else begin
                        sel_wait++;
                    end
                end

                if (o_en_t && done_at != 0 && en_cnt == done_at) begin
                    i_decoder_done = 1'b1;
                    i_decoder_data = data;
                end else begin
                    i_decoder_done = 1'b0;
                    i_decoder_data = 8'($urandom);
                end

                if (o_out_valid) i_out_ready = (val_cnt > rdy_dly);
                else i_out_ready = 1'($urandom_range(0, 1));

                @(negedge clk);
                cyc++;
                if (cyc > 300) begin
                    check({name, ":cycle_budget"}, 32'd0, 32'd1);
                    do_reset({name, ":recover"});
                    return;
                end
            end
        end

        timeout = (done_at == 0);
        if (timeout) exp_err = 1'b1;

        check({name, ":acs_count"}, 32'(acs_cnt), 32'(STEPS));
        for (int i = 0; i < STEPS; i++)
            check({name, ":addr"}, (i < addrs.size()) ? 32'(addrs[i]) : 32'hffff_ffff, 32'(i));
        check({name, ":sel_count"}, 32'(sel_cnt), 32'd1);
        check({name, ":sel_cycle"}, 32'(sel_cyc), 32'(last_acs_cyc));
        check({name, ":en_t_cycles"}, 32'(en_cnt), timeout ? 32'(TB_TIMEOUT) : 32'(done_at));
        check({name, ":valid_cycles"}, 32'(val_cnt), timeout ? 32'd0 : 32'(rdy_dly + 1));
        check({name, ":err"},      32'(o_err),      32'(exp_err));
        check({name, ":idle_busy"}, 32'(o_busy),     32'd0);
        check({name, ":idle_ready"}, 32'(o_in_ready), 32'd1);
        check({name, ":idle_empty"}, 32'(o_td_empty), 32'd1);
    endtask

    initial begin
        do_reset("reset");

        run_block("b2b",     2, 4,  8'hA5, 0, 16'h0000, 0, 0);
        // Pattern 1,0,0,1,1,0,1 read LSB first.
        run_block("gapped",  1, 3,  8'h5A, 0, 16'b1011001, 7, 0);
        run_block("backpr",  0, 2,  8'hC3, 5, 16'h0000, 0, 0);
        run_block("timeout", 1, 0,  8'h00, 0, 16'h0000, 0, 0);
        run_block("sticky",  3, 5,  8'h17, 1, 16'h0000, -1, 0);
        run_block("abort",   2, 8,  8'hEE, 0, 16'h0000, 0, 3);
        run_block("post_rst", 1, 4, 8'h3C, 0, 16'h0000, 0, 0);
        run_block("done_edge", 0, TB_TIMEOUT, 8'h96, 2, 16'h0000, 0, 0);

        for (int n = 0; n < 20; n++) begin
            int         sd, da, rd;
            logic [7:0] d;
            sd = $urandom_range(0, 4);
            da = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, TB_TIMEOUT);
            rd = $urandom_range(0, 3);
            d  = 8'($urandom);
            run_block($sformatf("rand%0d", n), sd, da, d, rd, 16'h0000, -1, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/viterbi_ctrl.md
VITERBI_CTRL -- requirements
Module: viterbi_ctrl

Interface
REQ-001 Parameter STEPS, default 4, radix-4 trellis steps (2 decoded bits each) per output byte.
REQ-002 Parameter TB_TIMEOUT, default 15, maximum TB-state cycles allowed before i_decoder_done.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 i_in_valid  in  1  branch-metric symbol available upstream.
REQ-006 o_in_ready  out  1  controller accepts a symbol this cycle.
REQ-007 o_acs_en  out  1  one-cycle strobe: ACS unit processes the accepted symbol.
REQ-008 o_mem_wr  out  1  survivor-memory write strobe, coincident with o_acs_en.
REQ-009 o_mem_addr  out  2  survivor-memory write address, equal to the current step index.
REQ-010 o_td_empty  out  1  survivor memory holds no steps of the current block.
REQ-011 o_sel_start  out  1  one-cycle pulse starting the best-node search.
REQ-012 i_sel_done  in  1  best-node search complete; i_sel_node valid.
REQ-013 o_en_t  out  1  traceback enable.
REQ-014 i_decoder_done  in  1  traceback reports byte complete (combinational from traceback).
REQ-015 i_decoder_data  in  8  traceback output byte.
REQ-016 o_out_valid / o_out_data  out  1 / 8  decoded byte and its valid flag.
REQ-017 i_out_ready  in  1  downstream accepts o_out_data.
REQ-018 o_busy  out  1  state is not IDLE.
REQ-019 o_err  out  1  sticky traceback-timeout flag.

Function
REQ-020 FSM states: IDLE, ACS, SEL, TB, OUT; 3-bit encoding; no other reachable states.
REQ-021 IDLE: o_in_ready=1; on i_in_valid&&o_in_ready, set step=0, pulse o_acs_en/o_mem_wr with o_mem_addr=0, then step=1 and go to ACS.
REQ-022 ACS: o_in_ready=1; each handshake pulses o_acs_en/o_mem_wr with o_mem_addr=step, then increments step; without i_in_valid, no strobes and the FSM holds.
REQ-023 When the handshake storing step STEPS-1 occurs, o_in_ready drops the next cycle, step resets to 0, and the FSM goes to SEL.
REQ-024 SEL: o_sel_start pulses high exactly in the first SEL cycle; the FSM waits for i_sel_done and then goes to TB; the wait has no timeout.
REQ-025 TB: o_en_t=1 in every TB cycle; a timeout counter counts up from 0.
REQ-026 TB exit: in the cycle i_decoder_done=1, register i_decoder_data into o_out_data before o_en_t drops (traceback clears its data when en_t is low); go to OUT.
REQ-027 TB timeout: if the counter reaches TB_TIMEOUT without i_decoder_done, set o_err=1, go to IDLE, and emit no output.
REQ-028 OUT: o_out_valid=1 with o_out_data stable until i_out_ready=1; return to IDLE the next cycle; a byte is never dropped or duplicated.
REQ-029 o_in_ready=0 in SEL, TB and OUT; i_in_valid in those states is ignored and not consumed.
REQ-030 o_td_empty=1 in IDLE and in ACS while step==0; 0 otherwise.
REQ-031 o_sel_start and o_acs_en never coincide with o_en_t.
REQ-032 o_err is cleared only by reset.

Reset
REQ-033 While rst=0: FSM=IDLE, step=0, timeout counter=0, o_out_data=0x00, o_err=0, o_out_valid=0, o_acs_en=0, o_mem_wr=0, o_sel_start=0, o_en_t=0, o_mem_addr=0, o_busy=0, o_td_empty=1, o_in_ready=0.
REQ-034 o_in_ready rises only in the first clock edge after rst deasserts.
REQ-035 Reset asserted mid-operation (any state) aborts immediately; any partial block is discarded; no o_out_valid until a full new block completes.

Verification
REQ-036 4 back-to-back symbols, sel_done 2 cycles after o_sel_start, decoder_done on the 4th o_en_t cycle with data 0xA5, i_out_ready=1 -> mem_addr sequence 0,1,2,3; exactly one o_sel_start; o_out_data=0xA5 valid for 1 cycle; back in IDLE.
REQ-037 i_in_valid gapped (1,0,0,1,1,0,1) -> exactly 4 acs strobes, addresses 0..3, SEL entered one cycle after the 4th handshake.
REQ-038 i_out_ready held low 5 cycles in OUT, i_in_valid=1 throughout -> o_out_valid high 6 cycles, data stable, o_in_ready=0, no acs strobe.
REQ-039 i_decoder_done never asserted -> o_en_t high exactly 15 cycles, o_err=1, FSM IDLE, no o_out_valid, o_err persists through the next block.
REQ-040 rst pulsed low during TB -> o_en_t=0 and o_err=0 asynchronously; next block with data 0x3C decodes normally.
REQ-041 i_decoder_done coincident with the timeout expiry cycle -> done wins; data captured, o_err stays 0.
